monobit: RTL and testbench

- Tiny Tapeout user block that runs the NIST SP800-22 frequency (monobit) test on a serial bitstream fed through `ui_in`.
- Counts ones over fixed blocks of N_BITS accepted bits.
- At each block end it latches a pass/fail verdict (|S| <= THRESH, where S = 2·ones − N_BITS) and the ones count.
- Top-level user macro; all I/O goes through the standard Tiny Tapeout pin set.

---
 rtl/monobit.sv | 98 +++++++++
 tb/tb_monobit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/monobit.sv
// monobit: NIST SP800-22 frequency (monobit) test on a serial bitstream.
// Bits arrive on ui_in[0] qualified by ui_in[1]. After every N_BITS accepted
// bits the block latches the ones count and a pass/fail verdict
// (|2*ones - N_BITS| <= THRESH), then starts the next block.
module monobit #(
  parameter int N_BITS = 128,
  parameter int THRESH = 29
) (
  input  logic       clk,
  input  logic       rst_n,    // synchronous, active-high despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Counters are 8 bits wide, so the block length must fit below 256.
  if (N_BITS < 2 || N_BITS > 254) begin : g_bad_n_bits
    $error("monobit: N_BITS must be in 2..254");
  end

  localparam logic [7:0]         LP_LAST   = 8'(N_BITS - 1);
  localparam logic signed [10:0] LP_N_BITS = 11'(N_BITS);
  localparam logic [10:0]        LP_THRESH = 11'(THRESH);

  // Decoded input strobes.
  logic w_data;
  logic w_strobe;
  logic w_clear;
  assign w_data   = ui_in[0];
  assign w_strobe = ui_in[1];
  assign w_clear  = ui_in[2];

  // Enable, bidirectional inputs and the spare ui_in bits carry no function.
  logic w_unused;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

  logic [7:0] r_bit_cnt;       // bits accepted in the current block
  logic [7:0] r_ones_cnt;      // ones accepted in the current block
  logic       r_result_valid;
  logic       r_pass;
  logic [7:0] r_ones_latched;  // ones count of the last completed block
  logic [4:0] r_blk_cnt;       // completed blocks, mod 32

  // The bit on the input completes the block when N_BITS-1 are already in.
  logic w_last;
  assign w_last = (r_bit_cnt == LP_LAST);

  // Ones count including the bit being accepted this cycle.
  logic [8:0] w_final;
  assign w_final = {1'b0, r_ones_cnt} + {8'd0, w_data};

  // S = 2*final - N_BITS, 11-bit signed so final=0 and final=N_BITS both fit.
  logic signed [10:0] w_s;
  logic        [10:0] w_abs_s;
  logic               w_pass;
  assign w_s     = $signed({1'b0, w_final, 1'b0}) - LP_N_BITS;
  assign w_abs_s = w_s[10] ? $unsigned(-w_s) : $unsigned(w_s);
  assign w_pass  = (w_abs_s <= LP_THRESH);

  // Block accumulation, completion latching, reset and clear handling.
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates in one edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_bit_cnt      <= '0;
      r_ones_cnt     <= '0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
      r_ones_latched <= '0;
      r_blk_cnt      <= '0;
    end else if (w_clear) begin
      // Restart the block; the last verdict stays visible.
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (w_strobe) begin
      if (w_last) begin
        r_pass         <= w_pass;
        r_ones_latched <= w_final[7:0];
        r_result_valid <= 1'b1;
        r_blk_cnt      <= r_blk_cnt + 5'd1;
        r_bit_cnt      <= '0;
        r_ones_cnt     <= '0;
      end else begin
        r_bit_cnt  <= r_bit_cnt + 8'd1;
        r_ones_cnt <= r_ones_cnt + {7'd0, w_data};
      end
    end
  end

  // Outputs come straight from registers; busy is a decode of bit_cnt only.
  assign uo_out  = {r_blk_cnt, (r_bit_cnt != 8'd0), r_pass, r_result_valid};
  assign uio_out = r_ones_latched;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_monobit.sv
// Self-checking bench for monobit: table of full-block vectors plus directed
// sequences for clear, wrap of the block counter and mid-block reset.
module tb_monobit;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  monobit #(.N_BITS(128), .THRESH(29)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full block: pattern description and hand-computed results.
  typedef struct {
    string      name;
    int         ones;      // ones-first: this many ones, then zeros
    bit         alt;       // alternating 1,0,1,0... instead of ones-first
    bit         gaps;      // idle cycle before every strobe
    logic [7:0] exp_ones;
    logic       exp_pass;
    logic [4:0] exp_blk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples on the next rising edge.
  task automatic put(input logic b, input logic v, input logic clr);
    @(negedge clk);
    ui_in = {5'b0, clr, v, b};
  endtask

  // One idle cycle; afterwards outputs reflect every earlier strobe.
  task automatic idle();
    put(1'b0, 1'b0, 1'b0);
  endtask

  // Feed bit indices [from, to) of a block pattern.
  task automatic feed_range(input int from, input int to, input int ones,
                            input bit alt, input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps) idle();
      put(alt ? logic'(i % 2 == 0) : logic'(i < ones), 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    //           name          ones alt gaps exp_ones pass blk
    vecs[0] = '{"alt",          0,  1, 0,   8'd64,  1'b1, 5'd1};
    vecs[1] = '{"all_ones",   128,  0, 0,   8'd128, 1'b0, 5'd2};
    vecs[2] = '{"all_zeros",    0,  0, 0,   8'd0,   1'b0, 5'd3};
    vecs[3] = '{"ones78",      78,  0, 0,   8'd78,  1'b1, 5'd4};
    vecs[4] = '{"ones79",      79,  0, 0,   8'd79,  1'b0, 5'd5};
    vecs[5] = '{"ones50",      50,  0, 0,   8'd50,  1'b1, 5'd6};
    vecs[6] = '{"ones49",      49,  0, 0,   8'd49,  1'b0, 5'd7};
    vecs[7] = '{"alt_gaps",     0,  1, 1,   8'd64,  1'b1, 5'd8};

    ena    = 1'b1;
    uio_in = 8'hA5;
    ui_in  = 8'h00;
    rst_n  = 1'b0;

    // Reset state.
    do_reset();
    idle();
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'hFF);

    // Full-block vectors, with a mid-block look at busy and held results.
    for (int v = 0; v < 8; v++) begin
      logic [7:0] mid_uo, mid_ones;
      if (v == 0) begin
        mid_uo   = 8'h04;
        mid_ones = 8'h00;
      end else begin
        mid_uo   = {vecs[v-1].exp_blk, 1'b1, vecs[v-1].exp_pass, 1'b1};
        mid_ones = vecs[v-1].exp_ones;
      end
      feed_range(0, 64, vecs[v].ones, vecs[v].alt, vecs[v].gaps);
      idle();
      check({vecs[v].name, "_mid_uo"}, uo_out, mid_uo);
      check({vecs[v].name, "_mid_ones"}, uio_out, mid_ones);
      feed_range(64, 128, vecs[v].ones, vecs[v].alt, vecs[v].gaps);
      idle();
      check({vecs[v].name, "_uo"}, uo_out,
            {vecs[v].exp_blk, 1'b0, vecs[v].exp_pass, 1'b1});
      check({vecs[v].name, "_ones"}, uio_out, vecs[v].exp_ones);
    end

    // Idle cycles change nothing.
    repeat (5) idle();
    check("idle_hold_uo", uo_out, 8'h43);
    check("idle_hold_ones", uio_out, 8'd64);

    // 24 more blocks bring the counter from 8 through 31 back to 0.
    for (int b = 0; b < 24; b++) feed_range(0, 128, 0, 1'b1, 1'b0);
    idle();
    check("wrap_uo", uo_out, 8'h03);

    // Known prior result: 78 ones -> pass, block 1.
    feed_range(0, 128, 78, 1'b0, 1'b0);
    idle();
    check("pre_clear_uo", uo_out, 8'h0B);

    // 40 ones, then clear together with a strobed 1 that must be dropped.
    feed_range(0, 40, 128, 1'b0, 1'b0);
    put(1'b1, 1'b1, 1'b1);
    idle();
    check("clear_uo", uo_out, 8'h0B);
    check("clear_ones", uio_out, 8'd78);

    // 127 bits of a fresh 64-ones block: no completion yet.
    feed_range(0, 127, 64, 1'b0, 1'b0);
    idle();
    check("clear_127_uo", uo_out, 8'h0F);
    check("clear_127_ones", uio_out, 8'd78);
    feed_range(127, 128, 64, 1'b0, 1'b0);
    idle();
    check("clear_done_uo", uo_out, 8'h13);
    check("clear_done_ones", uio_out, 8'd64);

    // Reset part way through a block clears every output.
    feed_range(0, 30, 128, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = 8'h03;
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = 8'h00;
    check("midrst_uo", uo_out, 8'h00);
    check("midrst_ones", uio_out, 8'h00);

    // Block after reset starts from zero: first block gives counter 1.
    feed_range(0, 128, 0, 1'b1, 1'b0);
    idle();
    check("post_rst_uo", uo_out, 8'h0B);
    check("post_rst_ones", uio_out, 8'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-away guard.
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL timeout: got no end of test, expected finish before 2000000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
